cpu_stage_sequencer: RTL and testbench

//  Multi-cycle control FSM for the single-issue RISC-V core.
//  - Drives stage enables FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITE for the cpu datapath.
//  - Handshakes with instruction memory and data memory via req/ack.
//  - Gates PC and register-file writes; provides halt and ack-timeout error detection.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/seq_perf_counter.sv | 40 ++++
 rtl/cpu_stage_sequencer.sv | 131 +++++++++++++
 tb/tb_cpu_stage_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the single-issue core's control path: sequencer state
// encoding and a small state-decode helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WRITE   = 3'd5,
    HALTED  = 3'd6,
    ERROR   = 3'd7
  } seq_state_t;

  localparam int PERF_W = 32;

  function automatic logic state_is_busy(input seq_state_t s);
    return !(s == IDLE || s == HALTED || s == ERROR);
  endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// Busy-cycle and retired-instruction counters for the stage sequencer.
// Present only when SEQ_PERF_CNT_EN is defined.
`ifdef SEQ_PERF_CNT_EN
module seq_perf_counter
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              retire,
  output logic [PERF_W-1:0] cycles,
  output logic [PERF_W-1:0] instret
);

  logic [PERF_W-1:0] cycles_q, cycles_d;
  logic [PERF_W-1:0] instret_q, instret_d;

  // Both counters wrap naturally at 2^32.
  always_comb begin
    cycles_d  = cycles_q;
    instret_d = instret_q;
    if (busy)   cycles_d  = cycles_q + 1'b1;
    if (retire) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
    end
  end

  assign cycles  = cycles_q;
  assign instret = instret_q;

endmodule
`endif

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITE control FSM with memory ack
// timeout. SEQ_PERF_CNT_EN adds CYCLES/INSTRET performance counters.
module cpu_stage_sequencer
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        HALT_REQ,
  output logic        IMEM_REQ,
  input  logic        IMEM_ACK,
  output logic        FETCH_EN,
  output logic        DECODE_EN,
  output logic        EXEC_EN,
  input  logic        IS_LOAD,
  input  logic        IS_STORE,
  input  logic        HAS_RD,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  input  logic        DMEM_ACK,
  output logic        PC_WE,
  output logic        RF_WE,
  output logic        BUSY,
  output logic        ERR,
  output logic [2:0]  STATE
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] CYCLES,
  output logic [31:0] INSTRET
`endif
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             is_store_q, is_store_d;
  logic             has_rd_q, has_rd_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    is_store_d = is_store_q;
    has_rd_d   = has_rd_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = FETCH;
          wait_cnt_d = '0;
        end
      end
      FETCH: begin
        if (IMEM_ACK)                  state_d    = DECODE;
        else if (wait_cnt_q == CNT_LAST) state_d  = ERROR;
        else                           wait_cnt_d = wait_cnt_q + 1'b1;
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        // A load+store decode collapses to a store via the latched store flag.
        is_store_d = IS_STORE;
        has_rd_d   = HAS_RD;
        if (IS_LOAD || IS_STORE) begin
          state_d    = MEM;
          wait_cnt_d = '0;
        end else begin
          state_d = WRITE;
        end
      end
      MEM: begin
        if (DMEM_ACK)                  state_d    = WRITE;
        else if (wait_cnt_q == CNT_LAST) state_d  = ERROR;
        else                           wait_cnt_d = wait_cnt_q + 1'b1;
      end
      WRITE: begin
        if (HALT_REQ) begin
          state_d = HALTED;
        end else begin
          state_d    = FETCH;
          wait_cnt_d = '0;
        end
      end
      HALTED: begin
        if (!START) state_d = IDLE;
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      is_store_q <= 1'b0;
      has_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      is_store_q <= is_store_d;
      has_rd_q   <= has_rd_d;
    end
  end

  // Moore decode only: nothing here depends on a live input.
  assign IMEM_REQ  = (state_q == FETCH);
  assign FETCH_EN  = (state_q == FETCH);
  assign DECODE_EN = (state_q == DECODE);
  assign EXEC_EN   = (state_q == EXECUTE);
  assign DMEM_REQ  = (state_q == MEM);
  assign DMEM_WE   = (state_q == MEM) && is_store_q;
  assign PC_WE     = (state_q == WRITE);
  assign RF_WE     = (state_q == WRITE) && has_rd_q && !is_store_q;
  assign BUSY      = state_is_busy(state_q);
  assign ERR       = (state_q == ERROR);
  assign STATE     = 3'(state_q);

`ifdef SEQ_PERF_CNT_EN
  seq_perf_counter u_perf (
    .clk     (CLK),
    .rst     (RST),
    .busy    (BUSY),
    .retire  (state_q == WRITE),
    .cycles  (CYCLES),
    .instret (INSTRET)
  );
`endif

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed bench for cpu_stage_sequencer (ACK_TIMEOUT=8); counter checks
// are added when SEQ_PERF_CNT_EN is defined.
module tb_cpu_stage_sequencer;
  import cpu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, START, HALT_REQ, IMEM_ACK, IS_LOAD, IS_STORE, HAS_RD, DMEM_ACK;
  logic       IMEM_REQ, FETCH_EN, DECODE_EN, EXEC_EN, DMEM_REQ, DMEM_WE;
  logic       PC_WE, RF_WE, BUSY, ERR;
  logic [2:0] STATE;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] CYCLES, INSTRET;
`endif

  cpu_stage_sequencer #(.ACK_TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .HALT_REQ(HALT_REQ),
    .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK), .FETCH_EN(FETCH_EN),
    .DECODE_EN(DECODE_EN), .EXEC_EN(EXEC_EN), .IS_LOAD(IS_LOAD),
    .IS_STORE(IS_STORE), .HAS_RD(HAS_RD), .DMEM_REQ(DMEM_REQ),
    .DMEM_WE(DMEM_WE), .DMEM_ACK(DMEM_ACK), .PC_WE(PC_WE), .RF_WE(RF_WE),
    .BUSY(BUSY), .ERR(ERR), .STATE(STATE)
`ifdef SEQ_PERF_CNT_EN
    , .CYCLES(CYCLES), .INSTRET(INSTRET)
`endif
  );

  always #5 CLK = ~CLK;

  // {IMEM_REQ,FETCH_EN,DECODE_EN,EXEC_EN,DMEM_REQ,DMEM_WE,PC_WE,RF_WE,BUSY,ERR}
  logic [9:0] outs;
  assign outs = {IMEM_REQ, FETCH_EN, DECODE_EN, EXEC_EN, DMEM_REQ, DMEM_WE,
                 PC_WE, RF_WE, BUSY, ERR};

  localparam logic [9:0] OUT_IDLE   = 10'b00_0000_0000;
  localparam logic [9:0] OUT_FETCH  = 10'b11_0000_0010;
  localparam logic [9:0] OUT_DEC    = 10'b00_1000_0010;
  localparam logic [9:0] OUT_EXE    = 10'b00_0100_0010;
  localparam logic [9:0] OUT_MEM_LD = 10'b00_0010_0010;
  localparam logic [9:0] OUT_MEM_ST = 10'b00_0011_0010;
  localparam logic [9:0] OUT_WR_RD  = 10'b00_0000_1110;
  localparam logic [9:0] OUT_WR_ST  = 10'b00_0000_1010;
  localparam logic [9:0] OUT_ERR    = 10'b00_0000_0001;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [9:0] o);
    check_eq({tag, "/state"}, 32'(STATE), 32'(st));
    check_eq({tag, "/outs"}, 32'(outs), 32'(o));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; HALT_REQ = 1'b0; IMEM_ACK = 1'b0;
    IS_LOAD = 1'b0; IS_STORE = 1'b0; HAS_RD = 1'b0; DMEM_ACK = 1'b0;
    #12;
    expect_cyc("reset", IDLE, OUT_IDLE);
`ifdef SEQ_PERF_CNT_EN
    check_eq("reset/cycles", CYCLES, 32'd0);
    check_eq("reset/instret", INSTRET, 32'd0);
`endif

    // ALU instruction with zero-wait fetch: period 4
    START = 1'b1; IMEM_ACK = 1'b1; HAS_RD = 1'b1;
    RST = 1'b0;
    step(); expect_cyc("alu_fetch", FETCH, OUT_FETCH);
    step(); expect_cyc("alu_dec", DECODE, OUT_DEC);
    step(); expect_cyc("alu_exe", EXECUTE, OUT_EXE);
    step(); expect_cyc("alu_wr", WRITE, OUT_WR_RD);
    step(); expect_cyc("alu_next_fetch", FETCH, OUT_FETCH);

    // Load with DMEM_ACK in the 4th MEM cycle
    IS_LOAD = 1'b1;
    step(); expect_cyc("ld_dec", DECODE, OUT_DEC);
    step(); expect_cyc("ld_exe", EXECUTE, OUT_EXE);
    step(); expect_cyc("ld_mem1", MEM, OUT_MEM_LD);
    IS_LOAD = 1'b0;
    step(); expect_cyc("ld_mem2", MEM, OUT_MEM_LD);
    step(); expect_cyc("ld_mem3", MEM, OUT_MEM_LD);
    step(); expect_cyc("ld_mem4", MEM, OUT_MEM_LD);
    DMEM_ACK = 1'b1;
    step(); expect_cyc("ld_wr", WRITE, OUT_WR_RD);
    DMEM_ACK = 1'b0;
    step(); expect_cyc("ld_next_fetch", FETCH, OUT_FETCH);

    // Store (load+store together decodes as store), HAS_RD=1
    IS_LOAD = 1'b1; IS_STORE = 1'b1;
    step(); expect_cyc("st_dec", DECODE, OUT_DEC);
    step(); expect_cyc("st_exe", EXECUTE, OUT_EXE);
    step(); expect_cyc("st_mem1", MEM, OUT_MEM_ST);
    IS_LOAD = 1'b0; IS_STORE = 1'b0;
    step(); expect_cyc("st_mem2", MEM, OUT_MEM_ST);
    DMEM_ACK = 1'b1;
    step(); expect_cyc("st_wr", WRITE, OUT_WR_ST);
    DMEM_ACK = 1'b0;

    // Halt requested in DECODE: instruction retires, then HALTED
    step(); expect_cyc("h_fetch", FETCH, OUT_FETCH);
    step(); expect_cyc("h_dec", DECODE, OUT_DEC);
    HALT_REQ = 1'b1;
    step(); expect_cyc("h_exe", EXECUTE, OUT_EXE);
    step(); expect_cyc("h_wr", WRITE, OUT_WR_RD);
    step(); expect_cyc("h_halted", HALTED, OUT_IDLE);
`ifdef SEQ_PERF_CNT_EN
    check_eq("h_instret", INSTRET, 32'd4);
`endif
    step(); expect_cyc("h_halted_hold", HALTED, OUT_IDLE);
    START = 1'b0;
    step(); expect_cyc("h_idle", IDLE, OUT_IDLE);
    HALT_REQ = 1'b0;

    // START dropped mid-instruction is ignored; RST in MEM aborts at once
    START = 1'b1; IS_LOAD = 1'b1;
    step(); expect_cyc("r_fetch", FETCH, OUT_FETCH);
    START = 1'b0;
    step(); expect_cyc("r_dec", DECODE, OUT_DEC);
    step(); expect_cyc("r_exe", EXECUTE, OUT_EXE);
    step(); expect_cyc("r_mem", MEM, OUT_MEM_LD);
    #2 RST = 1'b1;
    #1;
    expect_cyc("r_async", IDLE, OUT_IDLE);
`ifdef SEQ_PERF_CNT_EN
    check_eq("r_cycles", CYCLES, 32'd0);
    check_eq("r_instret", INSTRET, 32'd0);
`endif
    IS_LOAD = 1'b0;
    step();
    RST = 1'b0;
    step(); expect_cyc("r_idle_stay", IDLE, OUT_IDLE);

    // Fetch timeout: 8 FETCH cycles without ack -> ERROR
    START = 1'b1; IMEM_ACK = 1'b0;
    step(); expect_cyc("to_fetch1", FETCH, OUT_FETCH);
    for (int i = 2; i <= 8; i++) begin
      step();
      check_eq($sformatf("to_fetch%0d/state", i), 32'(STATE), 32'(FETCH));
    end
    step(); expect_cyc("to_error", ERROR, OUT_ERR);
    IMEM_ACK = 1'b1; DMEM_ACK = 1'b1; START = 1'b0;
    step(); expect_cyc("to_error_hold1", ERROR, OUT_ERR);
    step(); expect_cyc("to_error_hold2", ERROR, OUT_ERR);
    DMEM_ACK = 1'b0;

    // Ack on the last allowed FETCH cycle (count == ACK_TIMEOUT-1) is accepted
    RST = 1'b1; IMEM_ACK = 1'b0;
    #1;
    expect_cyc("b_reset", IDLE, OUT_IDLE);
    step();
    RST = 1'b0; START = 1'b1;
    step(); expect_cyc("b_fetch1", FETCH, OUT_FETCH);
    for (int i = 0; i < 7; i++) step();
    expect_cyc("b_fetch8", FETCH, OUT_FETCH);
    IMEM_ACK = 1'b1;
    step(); expect_cyc("b_dec", DECODE, OUT_DEC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
